// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port RAM between N_REQ requesters.
// Each access takes one ACCESS cycle, then a DONE cycle that issues ack and arbitrates the next grant.
module mem_arbiter #(
    parameter int N_REQ      = 3,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0]              lock,
    input  logic [N_REQ-1:0]              we,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]   wdata,
    output logic [N_REQ-1:0]              gnt,
    output logic [N_REQ-1:0]              ack,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          mem_CS,
    output logic                          mem_OE,
    output logic                          mem_WE,
    output logic                          busy
);

    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BURST_W = $clog2(MAX_BURST) + 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t               state_reg;
    logic [IDX_W-1:0]     last_winner_reg;
    logic [BURST_W-1:0]   burst_cnt_reg;

    logic [ADDR_WIDTH-1:0] addr_arr  [N_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic [N_REQ-1:0] elig_mask;
    logic             cont_burst;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] scan_idx;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;

    // The requester just served sits last in the scan order, so it only
    // re-wins a limit-capped burst when nobody else is asking.
    always_comb begin
        elig_mask  = req;
        cont_burst = 1'b0;
        win_found  = 1'b0;
        win_idx    = '0;
        scan_idx   = '0;
        if (state_reg == DONE) begin
            elig_mask[last_winner_reg] = req[last_winner_reg] & lock[last_winner_reg];
            cont_burst = elig_mask[last_winner_reg] && (burst_cnt_reg < BURST_LAST);
        end
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = IDX_W'((int'(last_winner_reg) + k) % N_REQ);
            if (!win_found && elig_mask[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
        sel_valid = cont_burst | win_found;
        sel_idx   = cont_burst ? last_winner_reg : win_idx;
    end

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            last_winner_reg <= IDX_LAST;
            burst_cnt_reg   <= '0;
            gnt             <= '0;
            ack             <= '0;
            rdata           <= '0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_CS          <= 1'b0;
            mem_OE          <= 1'b0;
            mem_WE          <= 1'b0;
        end else begin
            case (state_reg)
                ACCESS: begin
                    // The RAM performed the access on the falling edge; capture and release it.
                    if (mem_OE) begin
                        rdata <= mem_rdata;
                    end
                    ack       <= gnt;
                    mem_CS    <= 1'b0;
                    mem_OE    <= 1'b0;
                    mem_WE    <= 1'b0;
                    state_reg <= DONE;
                end
                default: begin
                    ack <= '0;
                    if (sel_valid) begin
                        state_reg       <= ACCESS;
                        gnt             <= N_REQ'(1) << sel_idx;
                        last_winner_reg <= sel_idx;
                        burst_cnt_reg   <= cont_burst ? burst_cnt_reg + BURST_W'(1) : '0;
                        mem_address     <= addr_arr[sel_idx];
                        mem_wdata       <= wdata_arr[sel_idx];
                        mem_WE          <= we[sel_idx];
                        mem_OE          <= ~we[sel_idx];
                        mem_CS          <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        gnt       <= '0;
                        mem_CS    <= 1'b0;
                        mem_OE    <= 1'b0;
                        mem_WE    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, read, write, round-robin, locked burst and reset mid-write.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req, lock, we;
    logic [47:0] addr;
    logic [23:0] wdata;
    logic [2:0]  gnt, ack;
    logic [7:0]  rdata;
    logic [15:0] mem_address;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_CS, mem_OE, mem_WE, busy;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.N_REQ(3), .ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_CS(mem_CS), .mem_OE(mem_OE), .mem_WE(mem_WE), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 3'b111; lock = 3'b000; we = 3'b000;
        addr = '0; wdata = '0; mem_rdata = 8'hFF;
        tick(); tick();
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
        checks++; if (ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b expected 000", ack); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
        checks++; if ({mem_CS, mem_OE, mem_WE} !== 3'b000) begin errors++; $display("FAIL reset_memctl: got %b expected 000", {mem_CS, mem_OE, mem_WE}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (mem_address !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", mem_address); end
        reset = 1'b1;
        tick();
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL reset_first_gnt: got %b expected 001", gnt); end
        tick();
        checks++; if (ack !== 3'b001) begin errors++; $display("FAIL reset_first_ack: got %b expected 001", ack); end
        $display("txn reset-release: ack=%b", ack);
        req = 3'b000;
        tick();
        checks++; if ({busy, gnt} !== 4'b0000) begin errors++; $display("FAIL reset_idle: got %b expected 0000", {busy, gnt}); end
    endtask

    task automatic test_single_read();
        req = 3'b010; we = 3'b000; addr[16 +: 16] = 16'h0012; mem_rdata = 8'hA5;
        tick();
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL read_gnt: got %b expected 010", gnt); end
        checks++; if (mem_address !== 16'h0012) begin errors++; $display("FAIL read_addr: got %h expected 0012", mem_address); end
        checks++; if ({mem_CS, mem_OE, mem_WE} !== 3'b110) begin errors++; $display("FAIL read_memctl: got %b expected 110", {mem_CS, mem_OE, mem_WE}); end
        tick();
        checks++; if (ack !== 3'b010) begin errors++; $display("FAIL read_ack: got %b expected 010", ack); end
        checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL read_rdata: got %h expected a5", rdata); end
        checks++; if ({mem_CS, mem_OE, mem_WE} !== 3'b000) begin errors++; $display("FAIL read_memctl_off: got %b expected 000", {mem_CS, mem_OE, mem_WE}); end
        $display("txn read: req1 addr=0012 rdata=%h", rdata);
        req = 3'b000;
        tick();
        checks++; if ({busy, gnt, ack} !== 7'b0) begin errors++; $display("FAIL read_idle: got %b expected 0000000", {busy, gnt, ack}); end
    endtask

    task automatic test_write();
        req = 3'b100; we = 3'b100; addr[32 +: 16] = 16'h0040; wdata[16 +: 8] = 8'h3C; mem_rdata = 8'h77;
        tick();
        checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL write_gnt: got %b expected 100", gnt); end
        checks++; if ({mem_CS, mem_OE, mem_WE} !== 3'b101) begin errors++; $display("FAIL write_memctl: got %b expected 101", {mem_CS, mem_OE, mem_WE}); end
        checks++; if ({mem_address, mem_wdata} !== {16'h0040, 8'h3C}) begin errors++; $display("FAIL write_bus: got %h expected 00403c", {mem_address, mem_wdata}); end
        tick();
        checks++; if (ack !== 3'b100) begin errors++; $display("FAIL write_ack: got %b expected 100", ack); end
        checks++; if (mem_WE !== 1'b0) begin errors++; $display("FAIL write_we_pulse: got %b expected 0", mem_WE); end
        checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL write_rdata_kept: got %h expected a5", rdata); end
        $display("txn write: req2 addr=0040 wdata=3c");
        req = 3'b000; we = 3'b000;
        tick();
        checks++; if ({busy, gnt} !== 4'b0000) begin errors++; $display("FAIL write_idle: got %b expected 0000", {busy, gnt}); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_oh;
        req = 3'b111; lock = 3'b000; we = 3'b000;
        for (int g = 0; g < 6; g++) begin
            exp_oh = 3'b001 << (g % 3);
            tick();
            checks++; if ({busy, gnt, ack} !== {1'b1, exp_oh, 3'b000}) begin errors++; $display("FAIL rr_gnt_%0d: got busy/gnt/ack %b expected %b", g, {busy, gnt, ack}, {1'b1, exp_oh, 3'b000}); end
            tick();
            checks++; if (ack !== exp_oh) begin errors++; $display("FAIL rr_ack_%0d: got %b expected %b", g, ack, exp_oh); end
            $display("txn rr %0d: ack=%b", g, ack);
        end
        req = 3'b000;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b expected 0", busy); end
    endtask

    task automatic test_locked_burst();
        req = 3'b011; lock = 3'b001; we = 3'b000;
        addr[0 +: 16] = 16'h0010; addr[16 +: 16] = 16'h0050;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({gnt, mem_address} !== {3'b001, 16'h0010 + 16'(i)}) begin errors++; $display("FAIL burst_gnt_%0d: got gnt %b addr %h expected 001 %h", i, gnt, mem_address, 16'h0010 + 16'(i)); end
            tick();
            checks++; if (ack !== 3'b001) begin errors++; $display("FAIL burst_ack_%0d: got %b expected 001", i, ack); end
            $display("txn burst %0d: addr=%h", i, 16'h0010 + 16'(i));
            addr[0 +: 16] = 16'h0011 + 16'(i);
        end
        tick();
        checks++; if ({gnt, mem_address} !== {3'b010, 16'h0050}) begin errors++; $display("FAIL burst_handoff: got gnt %b addr %h expected 010 0050", gnt, mem_address); end
        req = 3'b010; lock = 3'b000;
        tick();
        checks++; if (ack !== 3'b010) begin errors++; $display("FAIL burst_handoff_ack: got %b expected 010", ack); end
        req = 3'b000;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_idle: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_write();
        req = 3'b001; we = 3'b001; addr[0 +: 16] = 16'h0080; wdata[0 +: 8] = 8'h5A;
        tick();
        checks++; if ({gnt, mem_WE} !== 4'b0011) begin errors++; $display("FAIL midrst_start: got %b expected 0011", {gnt, mem_WE}); end
        reset = 1'b0;
        tick();
        checks++; if ({mem_WE, gnt, ack} !== 7'b0) begin errors++; $display("FAIL midrst_abort: got %b expected 0000000", {mem_WE, gnt, ack}); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL midrst_rdata: got %h expected 00", rdata); end
        reset = 1'b1; req = 3'b111; we = 3'b000;
        tick();
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL midrst_restart: got %b expected 001", gnt); end
        tick();
        checks++; if (ack !== 3'b001) begin errors++; $display("FAIL midrst_ack: got %b expected 001", ack); end
        $display("txn reset-mid-write: aborted, restart ack=%b", ack);
        req = 3'b000;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_locked_burst();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
